// File: rtl/sparc_inst_encoder_pkg.sv
// rtl/sparc_inst_encoder_pkg.sv - opcode, op3 and field-position constants for the SPARC encoder
package sparc_inst_pkg;

  localparam logic [1:0] OP_FMT2 = 2'b00;
  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_MEM  = 2'b11;

  localparam logic [5:0] OP3_MOVCC = 6'h2C;
  localparam logic [5:0] OP3_MOVR  = 6'h2F;
  localparam logic [5:0] OP3_FPOP2 = 6'h35;

  localparam int OP_LSB  = 30;
  localparam int RD_LSB  = 25;
  localparam int OP2_LSB = 22;
  localparam int OP3_LSB = 19;
  localparam int RS1_LSB = 14;
  localparam int I_BIT   = 13;

endpackage

// File: rtl/sparc_inst_encoder_if.sv
// rtl/sparc_inst_encoder_if.sv - request and instruction-queue handshake bundle
interface sparc_inst_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_rd;
  logic [5:0]  req_op3;
  logic [4:0]  req_rs1;
  logic        req_i;
  logic [29:0] req_imm;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic        inst_cls_mv;

  modport master (
    output req_valid, req_op, req_rd, req_op3, req_rs1, req_i, req_imm, inst_ready,
    input  req_ready, inst_valid, inst_word, inst_cls_mv
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_op3, req_rs1, req_i, req_imm, inst_ready,
    output req_ready, inst_valid, inst_word, inst_cls_mv
  );
endinterface

// File: rtl/sparc_inst_fifo.sv
// rtl/sparc_inst_fifo.sv - synchronous FIFO holding encoded words plus class flag
// Flush has priority over push and pop; empty head reads as zero.
module sparc_inst_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 33,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty & ~flush_i;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop) & ~flush_i;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  assign valid_o = ~empty;
  assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sparc_inst_encoder.sv
// rtl/sparc_inst_encoder.sv - encodes field requests into SPARC words and queues them for issue
// Encode/classify feed a stage register, which feeds the FIFO; credit covers stage plus FIFO.
module sparc_inst_encoder
  import sparc_inst_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 flush,
  sparc_inst_encoder_if.slave  bus,
  output logic                 err_pulse,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]      word_d;
  logic             cls_d, illegal, accept;
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_word_q;
  logic             s1_cls_q;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      occupancy;

  always_comb begin
    word_d = '0;
    word_d[OP_LSB +: 2] = bus.req_op;
    unique case (bus.req_op)
      OP_CALL: word_d[29:0] = bus.req_imm;
      OP_FMT2: begin
        word_d[RD_LSB +: 5]  = bus.req_rd;
        word_d[OP2_LSB +: 3] = bus.req_op3[2:0];
        word_d[21:0]         = bus.req_imm[21:0];
      end
      default: begin
        word_d[RD_LSB +: 5]  = bus.req_rd;
        word_d[OP3_LSB +: 6] = bus.req_op3;
        word_d[RS1_LSB +: 5] = bus.req_rs1;
        word_d[I_BIT]        = bus.req_i;
        word_d[12:0]         = bus.req_imm[12:0];
      end
    endcase
  end

  assign cls_d   = (bus.req_op == OP_ALU) &&
                   (bus.req_op3 == OP3_MOVCC || bus.req_op3 == OP3_MOVR ||
                    bus.req_op3 == OP3_FPOP2);
  assign illegal = (bus.req_op == OP_MEM) && (bus.req_op3[5:4] == 2'b01);

  // Credit uses registered state only, so inst_ready never reaches req_ready combinationally.
  assign occupancy     = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid_q};
  assign bus.req_ready = (occupancy < (CW+1)'(DEPTH));
  assign accept        = bus.req_valid & bus.req_ready;

  always_comb begin
    s1_valid_d  = accept & ~illegal & ~flush;
    err_pulse_d = accept & illegal & ~flush;
    err_cnt_d   = err_cnt_q;
    if (err_pulse_d && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid_q  <= 1'b0;
      s1_word_q   <= '0;
      s1_cls_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      if (accept) begin
        s1_word_q <= word_d;
        s1_cls_q  <= cls_d;
      end
    end
  end

  sparc_inst_fifo #(.DEPTH(DEPTH), .W(33)) u_fifo (
    .clk     (clk),
    .rst_l   (rst_l),
    .flush_i (flush),
    .push_i  (s1_valid_q),
    .data_i  ({s1_cls_q, s1_word_q}),
    .pop_i   (bus.inst_ready),
    .valid_o (bus.inst_valid),
    .data_o  ({bus.inst_cls_mv, bus.inst_word}),
    .count_o (fifo_count)
  );

  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule
